prog_mem_loader: RTL and testbench
==================================

// Module: prog_mem_loader
// PURPOSE
//  Parametrised UART-to-program-memory loader. Captures one DATA_W-bit word per rising edge of the UART
//  word-ready strobe and writes it to program memory at sequential addresses. Adds a word count, full and
//  error status, a restart input, and a selectable stop-at-full or wrap-around mode.
//  Sits between the UART word assembler and the program memory write port.
// PARAMETERS
//  DATA_W  32  instruction word width in bits
//  ADDR_W  3   program memory address width; DEPTH = 2**ADDR_W words
//  WRAP    0   0: stop loading when DEPTH words are written; 1: wrap to address 0 and overwrite, never full
// PORTS
//  clk              in   1            system clock, rising edge
//  rst              in   1            asynchronous, active-low reset
//  i_data_received  in   1            UART word-ready level; each 0->1 transition is one word
//  i_instruction    in   DATA_W       word from UART, valid when i_data_received is high
//  i_clear          in   1            synchronous restart of the load sequence; held one or more cycles
//  o_write_enable   out  1            program memory write strobe, exactly 1 cycle per accepted word
//  o_address        out  ADDR_W       write address, valid while o_write_enable is high
//  o_instruction    out  DATA_W       write data, valid while o_write_enable is high
//  o_count          out  ADDR_W+1     number of words written since reset or clear (saturates at DEPTH)
//  o_full           out  1            DEPTH words written (WRAP=0 only; tied 0 when WRAP=1)
//  o_busy           out  1            FSM is not in IDLE or FULL
//  o_error          out  1            sticky: a strobe edge was rejected
// BEHAVIOUR
//  - Reset: all outputs 0, FSM in IDLE, edge history register = 2'b00.
//  - Edge detect: 2-bit shift register sync[1:0] <= {sync[0], i_data_received}; an edge is sync==2'b01.
//  - FSM states: IDLE -> CAPTURE -> WRITE -> ADVANCE -> IDLE, or ADVANCE -> FULL.
//    IDLE:    on an edge, go to CAPTURE.
//    CAPTURE: o_instruction <= i_instruction.
//    WRITE:   o_write_enable = 1 for this one cycle; o_address and o_instruction are stable.
//    ADVANCE: o_write_enable = 0; o_address <= o_address+1 (mod DEPTH); o_count <= min(o_count+1, DEPTH).
//             WRAP=0 and o_count+1 == DEPTH: go to FULL and set o_full. Otherwise go to IDLE.
//    FULL:    no writes. o_address stays at 0 after the modulo increment. Exit only by i_clear or rst.
//  - Latency: edge seen at clock N -> o_write_enable high in cycle N+2 -> ready for the next edge at N+4.
//  - o_instruction returns to 0 in IDLE. o_busy is high in CAPTURE, WRITE and ADVANCE.
//  - Rejected edges: an edge that arrives in CAPTURE, WRITE, ADVANCE or FULL is dropped and sets o_error.
//  - WRAP=1: the address wraps from DEPTH-1 to 0, o_count saturates at DEPTH, o_full stays 0.
//  - i_clear has priority over every state and any same-cycle edge. On the next clock: FSM=IDLE,
//    o_address=0, o_count=0, o_full=0, o_error=0, o_write_enable=0.
//    If clear lands in WRITE, that strobe still ends after its single cycle.
//  - rst asserted mid-operation: immediate asynchronous return to the reset values; any partial word is lost.
// CONFIGURATION
//  - Macro LOADER_CHECKSUM_EN.
//  - Defined: adds output o_checksum [DATA_W-1:0]. It resets to 0, is cleared by i_clear, and is updated
//    o_checksum <= o_checksum ^ o_instruction in every WRITE cycle. It is a running XOR of all written words.
//  - Undefined: the port and its logic are absent; all other behaviour is identical.
// TESTING
//  1. Reset, then 3 strobes with 0x00000013, 0x00100093, 0x00000000 -> writes to addresses 0,1,2 with
//     exactly that data (the zero word is written); o_count=3; each o_write_enable pulse lasts 1 cycle.
//  2. WRAP=0, ADDR_W=3, 9 strobes -> 8 writes (addresses 0..7), o_full=1, o_count=8, 9th strobe gives no
//     write and o_error=1.
//  3. WRAP=1, ADDR_W=2, 5 strobes with data 1..5 -> address 0 rewritten with 5, o_full=0, o_count=4.
//  4. Second strobe edge 1 cycle after the first -> single write, o_error=1; i_clear then -> o_count=0,
//     o_error=0, o_address=0.
//  5. rst low while in WRITE -> o_write_enable=0 immediately, all outputs 0, next strobe writes address 0.
//  6. LOADER_CHECKSUM_EN defined, writes 0xA5A5A5A5 then 0x0F0F0F0F -> o_checksum=0xAAAAAAAA; i_clear -> 0.

Source files
------------

// File: rtl/prog_mem_loader_if.sv
// Bus between the UART word assembler side and the program memory write port
// of prog_mem_loader. The o_checksum member exists only when LOADER_CHECKSUM_EN
// is defined.
interface prog_mem_loader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
);
    logic              i_data_received;
    logic [DATA_W-1:0] i_instruction;
    logic              i_clear;
    logic              o_write_enable;
    logic [ADDR_W-1:0] o_address;
    logic [DATA_W-1:0] o_instruction;
    logic [ADDR_W:0]   o_count;
    logic              o_full;
    logic              o_busy;
    logic              o_error;
`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] o_checksum;
`endif

    // Loader side
    modport slave (
`ifdef LOADER_CHECKSUM_EN
        output o_checksum,
`endif
        input  i_data_received, i_instruction, i_clear,
        output o_write_enable, o_address, o_instruction, o_count,
        output o_full, o_busy, o_error
    );

    // Driver / observer side
    modport master (
`ifdef LOADER_CHECKSUM_EN
        input  o_checksum,
`endif
        output i_data_received, i_instruction, i_clear,
        input  o_write_enable, o_address, o_instruction, o_count,
        input  o_full, o_busy, o_error
    );
endinterface

// File: rtl/prog_mem_loader.sv
// UART-to-program-memory loader: one word per rising edge of the UART
// word-ready level, written at sequential addresses, with count, full,
// sticky error, synchronous restart and stop-at-full / wrap-around modes.
// Optional feature macro: LOADER_CHECKSUM_EN adds a running XOR of written words.
module prog_mem_loader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3,
    parameter int WRAP   = 0
) (
    input  logic              clk,
    input  logic              rst,
    prog_mem_loader_if.slave  bus
);
    localparam int unsigned     DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        WRITE,
        ADVANCE,
        FULL
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        sync;
    logic              strobe_edge;
    logic [ADDR_W-1:0] address;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   count_inc;
    logic [DATA_W-1:0] instr;
    logic              full;
    logic              error;
    logic              last_word;
    logic              write_en;
    logic              busy;

    assign strobe_edge = (sync == 2'b01);
    assign count_inc   = count + (ADDR_W + 1)'(1);
    // Only the stop-at-full mode ever terminates; wrap mode never sets full.
    assign last_word   = (WRAP == 0) && (count_inc == DEPTH_CNT);

    // Edge history of the UART word-ready level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync <= '0;
        else      sync <= {sync[0], bus.i_data_received};
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next state and state-decoded strobes; clear overrides any transition
    // but the write strobe stays tied to WRITE so it still lasts one cycle.
    always_comb begin
        state_nxt = state;
        write_en  = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE:    if (strobe_edge) state_nxt = CAPTURE;
            CAPTURE: begin
                busy      = 1'b1;
                state_nxt = WRITE;
            end
            WRITE: begin
                busy      = 1'b1;
                write_en  = 1'b1;
                state_nxt = ADVANCE;
            end
            ADVANCE: begin
                busy      = 1'b1;
                state_nxt = last_word ? FULL : IDLE;
            end
            FULL:    state_nxt = FULL;
            default: state_nxt = IDLE;
        endcase
        if (bus.i_clear) state_nxt = IDLE;
    end

    // Address, count, data and status registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            address <= '0;
            count   <= '0;
            instr   <= '0;
            full    <= 1'b0;
            error   <= 1'b0;
        end else if (bus.i_clear) begin
            address <= '0;
            count   <= '0;
            instr   <= '0;
            full    <= 1'b0;
            error   <= 1'b0;
        end else begin
            if (strobe_edge && (state != IDLE)) error <= 1'b1;
            case (state)
                CAPTURE: instr <= bus.i_instruction;
                ADVANCE: begin
                    address <= address + ADDR_W'(1);
                    count   <= (count == DEPTH_CNT) ? count : count_inc;
                    instr   <= '0;
                    if (last_word) full <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;

    // Running XOR of every word presented on the write port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                    checksum <= '0;
        else if (bus.i_clear)        checksum <= '0;
        else if (state == WRITE)     checksum <= checksum ^ instr;
    end

    assign bus.o_checksum = checksum;
`endif

    assign bus.o_write_enable = write_en;
    assign bus.o_address      = address;
    assign bus.o_instruction  = instr;
    assign bus.o_count        = count;
    assign bus.o_full         = full;
    assign bus.o_busy         = busy;
    assign bus.o_error        = error;
endmodule

// File: tb/tb_prog_mem_loader.sv
// Scoreboard bench for prog_mem_loader: two instances (stop-at-full with 8 words,
// wrap-around with 4 words). Expected writes are queued by the stimulus and
// popped by negedge monitors. LOADER_CHECKSUM_EN enables the checksum scenario.
module tb_prog_mem_loader;
    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    wr_t  q0[$];
    wr_t  q1[$];
    logic prev0 = 1'b0;
    logic prev1 = 1'b0;

    always #5 clk = ~clk;

    prog_mem_loader_if #(.DATA_W(32), .ADDR_W(3)) if0 ();
    prog_mem_loader_if #(.DATA_W(32), .ADDR_W(2)) if1 ();

    prog_mem_loader #(.DATA_W(32), .ADDR_W(3), .WRAP(0)) u0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    prog_mem_loader #(.DATA_W(32), .ADDR_W(2), .WRAP(1)) u1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor for the stop-at-full instance
    always @(negedge clk) begin
        if (if0.o_write_enable) begin
            wr_t e;
            n_cmp++;
            if (prev0) begin
                n_bad++;
                $display("FAIL we_pulse0: got 2+ cycles expected 1");
            end
            n_cmp++;
            if (q0.size() == 0) begin
                n_bad++;
                $display("FAIL write0: got addr %0d data 0x%0h expected no write",
                         if0.o_address, if0.o_instruction);
            end else begin
                e = q0.pop_front();
                if ({1'b0, if0.o_address} !== e.addr || if0.o_instruction !== e.data) begin
                    n_bad++;
                    $display("FAIL write0: got addr %0d data 0x%0h expected addr %0d data 0x%0h",
                             if0.o_address, if0.o_instruction, e.addr, e.data);
                end
            end
        end
        prev0 = if0.o_write_enable;
    end

    // Monitor for the wrap-around instance
    always @(negedge clk) begin
        if (if1.o_write_enable) begin
            wr_t e;
            n_cmp++;
            if (prev1) begin
                n_bad++;
                $display("FAIL we_pulse1: got 2+ cycles expected 1");
            end
            n_cmp++;
            if (q1.size() == 0) begin
                n_bad++;
                $display("FAIL write1: got addr %0d data 0x%0h expected no write",
                         if1.o_address, if1.o_instruction);
            end else begin
                e = q1.pop_front();
                if ({2'b00, if1.o_address} !== e.addr || if1.o_instruction !== e.data) begin
                    n_bad++;
                    $display("FAIL write1: got addr %0d data 0x%0h expected addr %0d data 0x%0h",
                             if1.o_address, if1.o_instruction, e.addr, e.data);
                end
            end
        end
        prev1 = if1.o_write_enable;
    end

    // One word: level high 3 cycles, low 3 cycles; optionally queue the expected write
    task automatic strobe(input int which, input logic [31:0] d,
                          input bit exp_wr, input logic [3:0] exp_addr);
        wr_t e;
        e.addr = exp_addr;
        e.data = d;
        if (exp_wr) begin
            if (which == 0) q0.push_back(e);
            else            q1.push_back(e);
        end
        @(negedge clk);
        if (which == 0) begin
            if0.i_instruction   = d;
            if0.i_data_received = 1'b1;
        end else begin
            if1.i_instruction   = d;
            if1.i_data_received = 1'b1;
        end
        repeat (3) @(negedge clk);
        if (which == 0) if0.i_data_received = 1'b0;
        else            if1.i_data_received = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic clear0();
        @(negedge clk);
        if0.i_clear = 1'b1;
        @(negedge clk);
        if0.i_clear = 1'b0;
    endtask

    initial begin
        if0.i_data_received = 1'b0;
        if0.i_instruction   = '0;
        if0.i_clear         = 1'b0;
        if1.i_data_received = 1'b0;
        if1.i_instruction   = '0;
        if1.i_clear         = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_we",    {63'd0, if0.o_write_enable}, 64'd0);
        chk("rst_addr",  {61'd0, if0.o_address},      64'd0);
        chk("rst_instr", {32'd0, if0.o_instruction},  64'd0);
        chk("rst_count", {60'd0, if0.o_count},        64'd0);
        chk("rst_flags", {61'd0, if0.o_full, if0.o_busy, if0.o_error}, 64'd0);
`ifdef LOADER_CHECKSUM_EN
        chk("rst_csum",  {32'd0, if0.o_checksum},     64'd0);
`endif
        rst = 1'b1;

        // Three words including an all-zero word
        strobe(0, 32'h0000_0013, 1'b1, 4'd0);
        strobe(0, 32'h0010_0093, 1'b1, 4'd1);
        strobe(0, 32'h0000_0000, 1'b1, 4'd2);
        chk("t1_count", {60'd0, if0.o_count},   64'd3);
        chk("t1_addr",  {61'd0, if0.o_address}, 64'd3);
        chk("t1_busy",  {63'd0, if0.o_busy},    64'd0);

        // Fill to DEPTH, ninth strobe rejected
        clear0();
        for (int i = 0; i < 8; i++)
            strobe(0, 32'h0000_0100 + 32'(i), 1'b1, 4'(i));
        chk("t2_full8",  {63'd0, if0.o_full},  64'd1);
        chk("t2_err8",   {63'd0, if0.o_error}, 64'd0);
        strobe(0, 32'hDEAD_BEEF, 1'b0, 4'd0);
        chk("t2_full",   {63'd0, if0.o_full},    64'd1);
        chk("t2_count",  {60'd0, if0.o_count},   64'd8);
        chk("t2_err",    {63'd0, if0.o_error},   64'd1);
        chk("t2_addr",   {61'd0, if0.o_address}, 64'd0);
        chk("t2_busy",   {63'd0, if0.o_busy},    64'd0);

        // Wrap mode, 4-word memory, five words
        strobe(1, 32'd1, 1'b1, 4'd0);
        strobe(1, 32'd2, 1'b1, 4'd1);
        strobe(1, 32'd3, 1'b1, 4'd2);
        strobe(1, 32'd4, 1'b1, 4'd3);
        strobe(1, 32'd5, 1'b1, 4'd0);
        chk("t3_full",  {63'd0, if1.o_full},    64'd0);
        chk("t3_count", {61'd0, if1.o_count},   64'd4);
        chk("t3_addr",  {62'd0, if1.o_address}, 64'd1);
        chk("t3_err",   {63'd0, if1.o_error},   64'd0);

        // Second edge while the first word is in flight
        clear0();
        chk("t4_clr_full", {63'd0, if0.o_full}, 64'd0);
        q0.push_back('{addr: 4'd0, data: 32'hCAFE_0001});
        @(negedge clk);
        if0.i_instruction   = 32'hCAFE_0001;
        if0.i_data_received = 1'b1;
        @(negedge clk);
        if0.i_data_received = 1'b0;
        @(negedge clk);
        if0.i_data_received = 1'b1;
        @(negedge clk);
        if0.i_data_received = 1'b0;
        repeat (4) @(negedge clk);
        chk("t4_err",   {63'd0, if0.o_error}, 64'd1);
        chk("t4_count", {60'd0, if0.o_count}, 64'd1);
        clear0();
        chk("t4_clr_count", {60'd0, if0.o_count},   64'd0);
        chk("t4_clr_err",   {63'd0, if0.o_error},   64'd0);
        chk("t4_clr_addr",  {61'd0, if0.o_address}, 64'd0);

        // Asynchronous reset while in WRITE
        @(negedge clk);
        if0.i_instruction   = 32'h1234_5678;
        if0.i_data_received = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t5_in_write", {63'd0, if0.o_write_enable}, 64'd1);
        rst = 1'b0;
        if0.i_data_received = 1'b0;
        #1;
        chk("t5_we",    {63'd0, if0.o_write_enable}, 64'd0);
        chk("t5_instr", {32'd0, if0.o_instruction},  64'd0);
        chk("t5_stat",  {56'd0, if0.o_count, if0.o_full, if0.o_busy, if0.o_error, 1'b0}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        strobe(0, 32'h8765_4321, 1'b1, 4'd0);
        chk("t5_count", {60'd0, if0.o_count}, 64'd1);

`ifdef LOADER_CHECKSUM_EN
        // Running XOR of written words
        clear0();
        strobe(0, 32'hA5A5_A5A5, 1'b1, 4'd0);
        chk("t6_csum1", {32'd0, if0.o_checksum}, 64'hA5A5_A5A5);
        strobe(0, 32'h0F0F_0F0F, 1'b1, 4'd1);
        chk("t6_csum2", {32'd0, if0.o_checksum}, 64'hAAAA_AAAA);
        clear0();
        chk("t6_csum_clr", {32'd0, if0.o_checksum}, 64'd0);
`endif

        repeat (4) @(negedge clk);
        chk("q0_empty", 64'(q0.size()), 64'd0);
        chk("q1_empty", 64'(q1.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
